// File: rtl/banked_register_file.sv
// Banked register file: NUM_GPR lane-addressed 32-bit GPRs, NUM_RD combinational
// read ports, custom registers (clk/esp/src/k) and a call/return save stack that
// snapshots every GPR.
// Optional build macro: BANKED_REGFILE_BYPASS_EN enables write-to-read forwarding.
module banked_register_file #(
  parameter int             NUM_GPR    = 4,
  parameter int             NUM_RD     = 3,
  parameter int             CODE_W     = 8,
  parameter int             SAVE_DEPTH = 16,
  parameter int             SP_W       = 16,
  parameter logic [SP_W-1:0] SP_RESET  = '1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wb_flag,
  input  logic [CODE_W-1:0]                wb_code,
  input  logic [31:0]                      wb_data,
  input  logic [NUM_RD*CODE_W-1:0]         rd_code,
  output logic [NUM_RD*32-1:0]             rd_value,
  input  logic [31:0]                      stack_top,
  input  logic [SP_W-1:0]                  stack_amount,
  input  logic                             call_flag,
  input  logic                             ret_flag,
  input  logic                             dma_sp_flag,
  input  logic [SP_W-1:0]                  dma_sp_data,
  output logic [NUM_GPR*32-1:0]            r_gpr,
  output logic [3:0]                       r_clk,
  output logic [SP_W-1:0]                  r_esp,
  output logic                             r_src,
  output logic [15:0]                      r_k,
  output logic [$clog2(SAVE_DEPTH+1)-1:0]  save_level,
  output logic                             save_full,
  output logic                             save_empty,
  output logic                             save_overflow,
  output logic                             save_underflow,
  output logic                             stack_push_flag,
  output logic [31:0]                      stack_push_value
);

  localparam int IDX_W  = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
  localparam int LVL_W  = $clog2(SAVE_DEPTH + 1);
  localparam int SIDX_W = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
  localparam int GPR_W  = NUM_GPR * 32;

  localparam logic [CODE_W-1:0] C_STACK_TOP = CODE_W'(32'h20);
  localparam logic [CODE_W-1:0] C_STACK_AMT = CODE_W'(32'h21);
  localparam logic [CODE_W-1:0] C_CLK       = CODE_W'(32'h22);
  localparam logic [CODE_W-1:0] C_ESP       = CODE_W'(32'h23);
  localparam logic [CODE_W-1:0] C_SRC       = CODE_W'(32'h24);
  localparam logic [CODE_W-1:0] C_K         = CODE_W'(32'h25);
  localparam logic [CODE_W-1:0] C_LEVEL     = CODE_W'(32'h26);

  // GPR code: top bit set, index in range, zero pad bits, non-reserved lane
  function automatic logic gpr_hit(input logic [CODE_W-1:0] c);
    return c[CODE_W-1]
        && (32'(c[CODE_W-2 -: IDX_W]) < NUM_GPR)
        && (32'(c[CODE_W-2-IDX_W:0]) < 8)
        && (c[2:0] != 3'b100);
  endfunction

  function automatic logic [31:0] lane_rd(input logic [31:0] v, input logic [2:0] lane);
    logic [31:0] r;
    r = '0;
    case (lane)
      3'b000:  r = v;
      3'b001:  r = {16'h0, v[15:0]};
      3'b010:  r = {24'h0, v[7:0]};
      3'b011:  r = {24'h0, v[15:8]};
      3'b101:  r = {16'h0, v[31:16]};
      3'b110:  r = {24'h0, v[23:16]};
      3'b111:  r = {24'h0, v[31:24]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_wr(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] lane);
    logic [31:0] r;
    r = old;
    case (lane)
      3'b000:  r        = d;
      3'b001:  r[15:0]  = d[15:0];
      3'b010:  r[7:0]   = d[7:0];
      3'b011:  r[15:8]  = d[7:0];
      3'b101:  r[31:16] = d[15:0];
      3'b110:  r[23:16] = d[7:0];
      3'b111:  r[31:24] = d[7:0];
      default: r        = old;
    endcase
    return r;
  endfunction

  logic [GPR_W-1:0] r_save_mem [SAVE_DEPTH];
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic             r_unf;
  logic             r_push_flag;
  logic [31:0]      r_push_value;

  logic              w_call;
  logic              w_ret;
  logic              w_do_push;
  logic              w_do_pop;
  logic [SIDX_W-1:0] w_push_idx;
  logic [SIDX_W-1:0] w_pop_idx;

  logic              w_wb_gpr;
  logic [IDX_W-1:0]  w_wb_idx;
  logic [2:0]        w_wb_lane;
  logic              w_wb_clk;
  logic              w_wb_esp;
  logic              w_wb_src;
  logic              w_wb_k;
  logic              w_wb_push;

  logic [GPR_W-1:0]  w_gpr_base;
  logic [31:0]       w_gpr_nxt [NUM_GPR];
  logic [31:0]       w_gpr_cur [NUM_GPR];
  logic [GPR_W-1:0]  w_gpr_nxt_flat;
  logic [3:0]        w_clk_nxt;
  logic [SP_W-1:0]   w_esp_nxt;
  logic              w_src_nxt;
  logic [15:0]       w_k_nxt;

  logic [3:0]        w_clk_rd;
  logic [SP_W-1:0]   w_esp_rd;
  logic              w_src_rd;
  logic [15:0]       w_k_rd;

  assign w_call     = call_flag & ~ret_flag;
  assign w_ret      = ret_flag & ~call_flag;
  assign save_full  = (r_level == LVL_W'(SAVE_DEPTH));
  assign save_empty = (r_level == '0);
  assign w_do_push  = w_call & ~save_full;
  assign w_do_pop   = w_ret & ~save_empty;
  assign w_push_idx = SIDX_W'(r_level);
  assign w_pop_idx  = SIDX_W'(r_level - LVL_W'(1));

  assign w_wb_gpr  = wb_flag & gpr_hit(wb_code);
  assign w_wb_idx  = wb_code[CODE_W-2 -: IDX_W];
  assign w_wb_lane = wb_code[2:0];
  assign w_wb_clk  = wb_flag & (wb_code == C_CLK);
  assign w_wb_esp  = wb_flag & (wb_code == C_ESP);
  assign w_wb_src  = wb_flag & (wb_code == C_SRC);
  assign w_wb_k    = wb_flag & (wb_code == C_K);
  assign w_wb_push = wb_flag & (wb_code == C_STACK_TOP);

  assign w_clk_nxt = w_wb_clk ? wb_data[3:0] : r_clk;
  assign w_esp_nxt = dma_sp_flag ? dma_sp_data : (w_wb_esp ? wb_data[SP_W-1:0] : r_esp);
  assign w_src_nxt = w_wb_src ? wb_data[0] : r_src;
  assign w_k_nxt   = w_wb_k ? wb_data[15:0] : r_k;

  // Restore is applied first so a same-cycle lane write can override the restored value
  assign w_gpr_base = w_do_pop ? r_save_mem[w_pop_idx] : r_gpr;

  // Next GPR values: restored/current base with the written lane merged in
  always_comb begin
    for (int unsigned n = 0; n < NUM_GPR; n++) begin
      w_gpr_nxt[n] = w_gpr_base[n*32 +: 32];
      if (w_wb_gpr && (w_wb_idx == IDX_W'(n))) begin
        w_gpr_nxt[n] = lane_wr(w_gpr_base[n*32 +: 32], wb_data, w_wb_lane);
      end
    end
  end

  for (genvar n = 0; n < NUM_GPR; n++) begin : g_pack
    assign w_gpr_nxt_flat[n*32 +: 32] = w_gpr_nxt[n];
    assign w_gpr_cur[n]               = r_gpr[n*32 +: 32];
  end

`ifdef BANKED_REGFILE_BYPASS_EN
  assign w_clk_rd = w_wb_clk ? w_clk_nxt : r_clk;
  assign w_esp_rd = w_wb_esp ? w_esp_nxt : r_esp;
  assign w_src_rd = w_wb_src ? w_src_nxt : r_src;
  assign w_k_rd   = w_wb_k   ? w_k_nxt   : r_k;
`else
  assign w_clk_rd = r_clk;
  assign w_esp_rd = r_esp;
  assign w_src_rd = r_src;
  assign w_k_rd   = r_k;
`endif

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [CODE_W-1:0] w_code;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_val;

    assign w_code = rd_code[g*CODE_W +: CODE_W];
    assign w_idx  = w_code[CODE_W-2 -: IDX_W];

    // Read-port decode: GPR lane or special register, zero-extended, 0 if unmatched
    always_comb begin
      w_val = '0;
      if (gpr_hit(w_code)) begin
`ifdef BANKED_REGFILE_BYPASS_EN
        if (w_wb_gpr && (w_wb_idx == w_idx)) begin
          w_val = lane_rd(w_gpr_nxt[w_idx], w_code[2:0]);
        end else begin
          w_val = lane_rd(w_gpr_cur[w_idx], w_code[2:0]);
        end
`else
        w_val = lane_rd(w_gpr_cur[w_idx], w_code[2:0]);
`endif
      end else begin
        case (w_code)
          C_STACK_TOP: w_val = stack_top;
          C_STACK_AMT: w_val = 32'(stack_amount);
          C_CLK:       w_val = 32'(w_clk_rd);
          C_ESP:       w_val = 32'(w_esp_rd);
          C_SRC:       w_val = 32'(w_src_rd);
          C_K:         w_val = 32'(w_k_rd);
          C_LEVEL:     w_val = 32'(r_level);
          default:     w_val = '0;
        endcase
      end
    end

    assign rd_value[g*32 +: 32] = w_val;
  end

  // Architectural registers, save-stack level and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gpr   <= '0;
      r_clk   <= '0;
      r_esp   <= SP_RESET;
      r_src   <= 1'b0;
      r_k     <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_gpr <= w_gpr_nxt_flat;
      r_clk <= w_clk_nxt;
      r_esp <= w_esp_nxt;
      r_src <= w_src_nxt;
      r_k   <= w_k_nxt;
      if (w_do_push) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_call && save_full) begin
        r_ovf <= 1'b1;
      end
      if (w_ret && save_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Save-stack storage; reset only clears the level, stale entries are never read
  always_ff @(posedge clock) begin
    if (!reset && w_do_push) begin
      r_save_mem[w_push_idx] <= r_gpr;
    end
  end

  // One-cycle push request toward the data-stack unit; value holds between requests
  always_ff @(posedge clock) begin
    if (reset) begin
      r_push_flag  <= 1'b0;
      r_push_value <= '0;
    end else begin
      r_push_flag <= w_wb_push;
      if (w_wb_push) begin
        r_push_value <= wb_data;
      end
    end
  end

  assign save_level       = r_level;
  assign save_overflow    = r_ovf;
  assign save_underflow   = r_unf;
  assign stack_push_flag  = r_push_flag;
  assign stack_push_value = r_push_value;

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: expectations are queued as stimulus
// is driven and compared once the DUT output is due.
module tb_banked_register_file;

  localparam int NUM_GPR    = 4;
  localparam int NUM_RD     = 3;
  localparam int CODE_W     = 8;
  localparam int SAVE_DEPTH = 16;
  localparam int SP_W       = 16;
  localparam int LVL_W      = $clog2(SAVE_DEPTH + 1);

  logic                        clock;
  logic                        reset;
  logic                        wb_flag;
  logic [CODE_W-1:0]           wb_code;
  logic [31:0]                 wb_data;
  logic [NUM_RD*CODE_W-1:0]    rd_code;
  logic [NUM_RD*32-1:0]        rd_value;
  logic [31:0]                 stack_top;
  logic [SP_W-1:0]             stack_amount;
  logic                        call_flag;
  logic                        ret_flag;
  logic                        dma_sp_flag;
  logic [SP_W-1:0]             dma_sp_data;
  logic [NUM_GPR*32-1:0]       r_gpr;
  logic [3:0]                  r_clk;
  logic [SP_W-1:0]             r_esp;
  logic                        r_src;
  logic [15:0]                 r_k;
  logic [LVL_W-1:0]            save_level;
  logic                        save_full;
  logic                        save_empty;
  logic                        save_overflow;
  logic                        save_underflow;
  logic                        stack_push_flag;
  logic [31:0]                 stack_push_value;

  banked_register_file #(
    .NUM_GPR    (NUM_GPR),
    .NUM_RD     (NUM_RD),
    .CODE_W     (CODE_W),
    .SAVE_DEPTH (SAVE_DEPTH),
    .SP_W       (SP_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_flag          (wb_flag),
    .wb_code          (wb_code),
    .wb_data          (wb_data),
    .rd_code          (rd_code),
    .rd_value         (rd_value),
    .stack_top        (stack_top),
    .stack_amount     (stack_amount),
    .call_flag        (call_flag),
    .ret_flag         (ret_flag),
    .dma_sp_flag      (dma_sp_flag),
    .dma_sp_data      (dma_sp_data),
    .r_gpr            (r_gpr),
    .r_clk            (r_clk),
    .r_esp            (r_esp),
    .r_src            (r_src),
    .r_k              (r_k),
    .save_level       (save_level),
    .save_full        (save_full),
    .save_empty       (save_empty),
    .save_overflow    (save_overflow),
    .save_underflow   (save_underflow),
    .stack_push_flag  (stack_push_flag),
    .stack_push_value (stack_push_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {
    O_GPR0, O_GPR1, O_GPR2, O_GPR3, O_RD0, O_RD1, O_RD2,
    O_LEVEL, O_FULL, O_EMPTY, O_OVF, O_UNF, O_PUSHF, O_PUSHV, O_ESP, O_CLK
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef BANKED_REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h77;
`else
  localparam logic [31:0] BYP_EXP = 32'h10;
`endif

  function automatic logic [31:0] obs(input obs_e s);
    case (s)
      O_GPR0:  return r_gpr[31:0];
      O_GPR1:  return r_gpr[63:32];
      O_GPR2:  return r_gpr[95:64];
      O_GPR3:  return r_gpr[127:96];
      O_RD0:   return rd_value[31:0];
      O_RD1:   return rd_value[63:32];
      O_RD2:   return rd_value[95:64];
      O_LEVEL: return 32'(save_level);
      O_FULL:  return 32'(save_full);
      O_EMPTY: return 32'(save_empty);
      O_OVF:   return 32'(save_overflow);
      O_UNF:   return 32'(save_underflow);
      O_PUSHF: return 32'(stack_push_flag);
      O_PUSHV: return stack_push_value;
      O_ESP:   return 32'(r_esp);
      O_CLK:   return 32'(r_clk);
      default: return '0;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_obs(input string tag, input obs_e sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_val(it.tag, obs(it.sel), it.exp);
    end
  endtask

  // Clock edge, compare registered results, return at the falling edge for new stimulus
  task automatic tick();
    @(posedge clock);
    #1;
    drain();
    @(negedge clock);
  endtask

  // Compare combinational results without crossing a clock edge
  task automatic settle();
    #1;
    drain();
  endtask

  task automatic idle();
    wb_flag     = 1'b0;
    wb_code     = '0;
    wb_data     = '0;
    call_flag   = 1'b0;
    ret_flag    = 1'b0;
    dma_sp_flag = 1'b0;
  endtask

  task automatic wb(input logic [7:0] code, input logic [31:0] data);
    wb_flag = 1'b1;
    wb_code = code;
    wb_data = data;
  endtask

  task automatic set_rd(input int port, input logic [7:0] code);
    rd_code[port*CODE_W +: CODE_W] = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    idle();
    rd_code      = '0;
    stack_top    = 32'hCAFEF00D;
    stack_amount = 16'h0042;
    dma_sp_data  = '0;
    @(posedge clock);

    expect_obs("rst_gpr0", O_GPR0, 32'h0);
    expect_obs("rst_gpr3", O_GPR3, 32'h0);
    expect_obs("rst_esp", O_ESP, 32'h0000FFFF);
    expect_obs("rst_clk", O_CLK, 32'h0);
    expect_obs("rst_level", O_LEVEL, 32'h0);
    expect_obs("rst_empty", O_EMPTY, 32'h1);
    expect_obs("rst_full", O_FULL, 32'h0);
    expect_obs("rst_ovf", O_OVF, 32'h0);
    expect_obs("rst_unf", O_UNF, 32'h0);
    expect_obs("rst_pushf", O_PUSHF, 32'h0);
    expect_obs("rst_pushv", O_PUSHV, 32'h0);
    tick();
    reset = 1'b0;

    // Lane writes and zero-extended lane reads
    wb(8'h80, 32'h11223344);
    expect_obs("wr_full", O_GPR0, 32'h11223344);
    tick();
    wb(8'h83, 32'h000000AB);
    expect_obs("wr_lane_15_8", O_GPR0, 32'h1122AB44);
    tick();
    idle();
    set_rd(0, 8'h86);
    set_rd(1, 8'h85);
    set_rd(2, 8'h84);
    expect_obs("rd_lane_23_16", O_RD0, 32'h00000022);
    expect_obs("rd_lane_31_16", O_RD1, 32'h00001122);
    expect_obs("rd_reserved", O_RD2, 32'h0);
    settle();
    set_rd(0, 8'hC8);
    set_rd(1, 8'h81);
    expect_obs("rd_pad_nz", O_RD0, 32'h0);
    expect_obs("rd_lane_15_0", O_RD1, 32'h0000AB44);
    settle();

    // Call / overwrite / return restores the snapshot
    wb(8'hA0, 32'hDEADBEEF);
    expect_obs("wr_ebx", O_GPR1, 32'hDEADBEEF);
    tick();
    idle();
    call_flag = 1'b1;
    expect_obs("call_level", O_LEVEL, 32'h1);
    expect_obs("call_empty", O_EMPTY, 32'h0);
    tick();
    idle();
    wb(8'hA0, 32'h5);
    expect_obs("ebx_overwrite", O_GPR1, 32'h5);
    tick();
    idle();
    ret_flag = 1'b1;
    expect_obs("ret_ebx", O_GPR1, 32'hDEADBEEF);
    expect_obs("ret_eax", O_GPR0, 32'h1122AB44);
    expect_obs("ret_level", O_LEVEL, 32'h0);
    expect_obs("ret_empty", O_EMPTY, 32'h1);
    tick();

    // Return with same-cycle write: written lane overrides restored value
    idle();
    wb(8'hC0, 32'h9);
    expect_obs("wr_ecx", O_GPR2, 32'h9);
    tick();
    idle();
    call_flag = 1'b1;
    tick();
    idle();
    wb(8'hC0, 32'h3);
    expect_obs("ecx_overwrite", O_GPR2, 32'h3);
    tick();
    idle();
    ret_flag = 1'b1;
    wb(8'hC0, 32'h7);
    expect_obs("ret_wr_ecx", O_GPR2, 32'h7);
    expect_obs("ret_wr_ebx", O_GPR1, 32'hDEADBEEF);
    expect_obs("ret_wr_level", O_LEVEL, 32'h0);
    tick();

    // Call with same-cycle write: snapshot holds pre-write value
    idle();
    wb(8'hE0, 32'h10);
    tick();
    idle();
    call_flag = 1'b1;
    wb(8'hE0, 32'h20);
    expect_obs("call_wr_edx", O_GPR3, 32'h20);
    expect_obs("call_wr_level", O_LEVEL, 32'h1);
    tick();
    idle();
    ret_flag = 1'b1;
    expect_obs("call_wr_restore", O_GPR3, 32'h10);
    tick();

    // Same-cycle read of the register being written
    idle();
    set_rd(0, 8'hE0);
    wb(8'hE0, 32'h77);
    expect_obs("bypass_rd", O_RD0, BYP_EXP);
    settle();
    expect_obs("bypass_wr", O_GPR3, 32'h77);
    tick();
    idle();
    expect_obs("post_wr_rd", O_RD0, 32'h77);
    settle();

    // Push request toward the data stack
    wb(8'h20, 32'h55);
    expect_obs("push_pre", O_PUSHF, 32'h0);
    settle();
    expect_obs("push_flag", O_PUSHF, 32'h1);
    expect_obs("push_val", O_PUSHV, 32'h55);
    tick();
    idle();
    expect_obs("push_drop", O_PUSHF, 32'h0);
    expect_obs("push_hold", O_PUSHV, 32'h55);
    tick();
    set_rd(0, 8'h20);
    set_rd(1, 8'h21);
    set_rd(2, 8'h26);
    expect_obs("rd_stack_top", O_RD0, 32'hCAFEF00D);
    expect_obs("rd_stack_amt", O_RD1, 32'h00000042);
    expect_obs("rd_level0", O_RD2, 32'h0);
    settle();

    // esp: DMA beats write-back; clk write truncates
    dma_sp_flag = 1'b1;
    dma_sp_data = 16'h1000;
    wb(8'h23, 32'h2000);
    expect_obs("esp_dma_prio", O_ESP, 32'h1000);
    tick();
    idle();
    wb(8'h23, 32'h2000);
    expect_obs("esp_wb", O_ESP, 32'h2000);
    tick();
    idle();
    wb(8'h22, 32'hFFFFFFFF);
    expect_obs("clk_wb", O_CLK, 32'hF);
    tick();
    idle();
    set_rd(0, 8'h23);
    set_rd(1, 8'h22);
    expect_obs("rd_esp", O_RD0, 32'h2000);
    expect_obs("rd_clk", O_RD1, 32'hF);
    settle();

    // Fill the save stack, then one call too many
    call_flag = 1'b1;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (i == SAVE_DEPTH - 1) begin
        expect_obs("fill_level", O_LEVEL, 32'(SAVE_DEPTH));
        expect_obs("fill_full", O_FULL, 32'h1);
        expect_obs("fill_ovf", O_OVF, 32'h0);
      end
      tick();
    end
    expect_obs("ovf_level", O_LEVEL, 32'(SAVE_DEPTH));
    expect_obs("ovf_flag", O_OVF, 32'h1);
    tick();
    ret_flag = 1'b1;
    expect_obs("both_level", O_LEVEL, 32'(SAVE_DEPTH));
    expect_obs("both_unf", O_UNF, 32'h0);
    tick();
    idle();
    set_rd(2, 8'h26);
    expect_obs("rd_level_full", O_RD2, 32'(SAVE_DEPTH));
    settle();

    // Drain, then return on an empty stack
    ret_flag = 1'b1;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (i == SAVE_DEPTH - 1) begin
        expect_obs("drain_level", O_LEVEL, 32'h0);
        expect_obs("drain_empty", O_EMPTY, 32'h1);
        expect_obs("drain_unf", O_UNF, 32'h0);
        expect_obs("drain_edx", O_GPR3, 32'h77);
        expect_obs("drain_ecx", O_GPR2, 32'h7);
      end
      tick();
    end
    idle();
    wb(8'h80, 32'h0BADF00D);
    tick();
    idle();
    ret_flag = 1'b1;
    expect_obs("unf_flag", O_UNF, 32'h1);
    expect_obs("unf_level", O_LEVEL, 32'h0);
    expect_obs("unf_gpr0", O_GPR0, 32'h0BADF00D);
    expect_obs("ovf_sticky", O_OVF, 32'h1);
    tick();

    // Reset mid-operation discards the save stack
    idle();
    call_flag = 1'b1;
    tick();
    tick();
    idle();
    reset = 1'b1;
    expect_obs("rst2_level", O_LEVEL, 32'h0);
    expect_obs("rst2_ovf", O_OVF, 32'h0);
    expect_obs("rst2_unf", O_UNF, 32'h0);
    expect_obs("rst2_gpr0", O_GPR0, 32'h0);
    expect_obs("rst2_esp", O_ESP, 32'h0000FFFF);
    tick();
    reset = 1'b0;
    ret_flag = 1'b1;
    expect_obs("rst2_ret_unf", O_UNF, 32'h1);
    expect_obs("rst2_ret_gpr1", O_GPR1, 32'h0);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
